fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/riscv_pkg.sv | 16 +
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: XLEN, the canonical NOP and the fetch-entry
// record that travels from fetch to decode.
package riscv_pkg;

   localparam int XLEN = 32;
   localparam logic [31:0] INST_NOP = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [31:0]     inst;
      logic            fault;
   } fetch_entry_t;

   localparam fetch_entry_t ENTRY_RESET = '{pc: '0, inst: INST_NOP, fault: 1'b0};

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous fetch buffer with flush. The head is read straight from storage registers,
// so nothing pushed in a cycle is visible on rdata before the following cycle.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t wdata,
   input  logic         pop,
   output fetch_entry_t rdata,
   output logic         full,
   output logic         empty
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t  mem [DEPTH];
   logic [AW:0]   wr_ptr;
   logic [AW:0]   rd_ptr;

   // Pointers carry one extra wrap bit to tell full from empty.
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= ENTRY_RESET;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, combinational imem lookup, FB_DEPTH-entry buffer
// toward decode. Optional macro FETCH_FAULT_EN enables misaligned/out-of-range fault tagging.
module fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              MEM_NBYTE = 4096,
   parameter int              FB_DEPTH  = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic [XLEN-1:0] imem_addr,
   input  logic [31:0]     imem_inst,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_pc,
   output logic [31:0]     out_inst,
   output logic            out_fault
);

   if ((FB_DEPTH < 2) || ((FB_DEPTH & (FB_DEPTH - 1)) != 0) || ((MEM_NBYTE % 4) != 0)) begin : g_bad_cfg
      $error("fetch_unit: FB_DEPTH must be a power of two >= 2 and MEM_NBYTE a multiple of 4");
   end

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] target;
   logic            full;
   logic            empty;
   logic            pop;
   logic            push;
   logic            can_fetch;
   fetch_entry_t    wentry;
   fetch_entry_t    head;

   assign imem_addr = pc;

   // Redirect wins over everything: the flush also blocks this cycle's push and pop.
   assign pop       = ~empty & out_ready & ~redirect_valid;
   assign can_fetch = ~redirect_valid & (~full | pop);

`ifdef FETCH_FAULT_EN
   localparam logic [XLEN-1:0] LAST_PC = XLEN'(MEM_NBYTE - 4);

   logic halted;
   logic bad_pc;

   assign bad_pc = (pc[1:0] != 2'b00) || (pc > LAST_PC);
   assign push   = can_fetch & ~halted;
   assign wentry = '{pc: pc, inst: (bad_pc ? INST_NOP : imem_inst), fault: bad_pc};
   assign target = redirect_pc;

   // A faulting fetch is the last one until software redirects somewhere sane.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         halted <= 1'b0;
      end else if (redirect_valid) begin
         halted <= 1'b0;
      end else if (push && bad_pc) begin
         halted <= 1'b1;
      end
   end
`else
   assign push   = can_fetch;
   assign wentry = '{pc: pc, inst: imem_inst, fault: 1'b0};
   assign target = {redirect_pc[XLEN-1:2], 2'b00};
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc <= RESET_PC;
      end else if (redirect_valid) begin
         pc <= target;
      end else if (push) begin
         pc <= pc + XLEN'(4);
      end
   end

   fetch_fifo #(
      .DEPTH (FB_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .wdata (wentry),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty)
   );

   assign out_valid = ~empty;
   assign out_pc    = head.pc;
   assign out_inst  = head.inst;
   // Without fault tagging every stored fault bit is zero, so this is constant 0.
   assign out_fault = head.fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a queue-based reference of the fetch buffer predicts
// every accepted entry; a negedge monitor compares handshakes, valid, imem_addr and stall stability.
module tb_fetch_unit;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam int          MEM_NBYTE = 4096;
   localparam int          FB_DEPTH  = 2;
   localparam logic [31:0] NOP       = 32'h0000_0013;
   localparam int          W         = 65;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_addr;
   logic [31:0] imem_inst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_inst;
   logic        out_fault;

   fetch_unit #(
      .RESET_PC  (RESET_PC),
      .MEM_NBYTE (MEM_NBYTE),
      .FB_DEPTH  (FB_DEPTH)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_addr      (imem_addr),
      .imem_inst      (imem_inst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_inst       (out_inst),
      .out_fault      (out_fault)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- instruction memory ----------------
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h0001_0003) ^ 32'h5A5A_0000;
   endfunction

   assign imem_inst = mem_word(imem_addr);

   // ---------------- reference model ----------------
   logic [31:0]  m_pc;
   logic [W-1:0] m_buf[$];
   bit           m_halt;
   bit           exp_valid;
   logic [W-1:0] exp_q[$];

   int checks = 0;
   int passed = 0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_pc = RESET_PC;
      m_buf.delete();
      m_halt = 0;
      exp_valid = 0;
   endtask

   // One clock edge of the fetch stage, described as queue operations.
   task automatic model_edge(input bit rdy, input bit rv, input logic [31:0] rpc);
      bit           do_pop;
      bit           room;
      logic [31:0]  inst;
      bit           fault;
      if (rv) begin
         m_buf.delete();
         m_halt = 0;
`ifdef FETCH_FAULT_EN
         m_pc = rpc;
`else
         m_pc = rpc - (rpc % 4);
`endif
      end else begin
         do_pop = (m_buf.size() > 0) && rdy;
         room   = (m_buf.size() < FB_DEPTH) || do_pop;
         if (do_pop) void'(m_buf.pop_front());
         if (room && !m_halt) begin
            inst  = mem_word(m_pc);
            fault = 0;
`ifdef FETCH_FAULT_EN
            if ((m_pc % 4 != 0) || (longint'(m_pc) > longint'(MEM_NBYTE - 4))) begin
               fault  = 1;
               inst   = NOP;
               m_halt = 1;
            end
`endif
            m_buf.push_back({m_pc, inst, fault});
            m_pc = m_pc + 32'd4;
         end
      end
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
      out_ready      = rdy;
      redirect_valid = rv;
      redirect_pc    = rpc;
      if (!rv && rdy && m_buf.size() > 0) exp_q.push_back(m_buf[0]);
      @(posedge clk);
      #1;
      model_edge(rdy, rv, rpc);
      exp_valid = (m_buf.size() > 0);
   endtask

   task automatic reset_pulse();
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      rst_n          = 1'b0;
      #1;
      check("rst_out_valid", W'(out_valid), W'(1'b0));
      check("rst_imem_addr", W'(imem_addr), W'(RESET_PC));
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // ---------------- monitor ----------------
   bit           prev_stall = 0;
   logic [W-1:0] prev_head;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 0;
      end else begin
         check("out_valid", W'(out_valid), W'(exp_valid));
         check("imem_addr", W'(imem_addr), W'(m_pc));
         if (prev_stall) check("stall_hold", {out_pc, out_inst, out_fault}, prev_head);
         if (out_valid && out_ready && !redirect_valid) begin
            if (exp_q.size() == 0) check("unexpected_pop", {out_pc, out_inst, out_fault}, '0 - 1'b1);
            else check("pop_entry", {out_pc, out_inst, out_fault}, exp_q.pop_front());
         end
         prev_stall = out_valid && !out_ready && !redirect_valid;
         prev_head  = {out_pc, out_inst, out_fault};
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst_n          = 1'b0;
      out_ready      = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      model_reset();
      #12;
      check("reset_out_valid", W'(out_valid), W'(1'b0));
      check("reset_out_pc",    W'(out_pc),    W'(32'h0));
      check("reset_out_inst",  W'(out_inst),  W'(NOP));
      check("reset_out_fault", W'(out_fault), W'(1'b0));
      check("reset_imem_addr", W'(imem_addr), W'(RESET_PC));
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Streaming with decode always ready: 0x0, 0x4, 0x8 back to back.
      for (int i = 0; i < 6; i++) step(1, 0, 0);

      // Decode stalled from reset: head 0x0 held, pc parks at 0x8 with two entries.
      reset_pulse();
      for (int i = 0; i < 5; i++) step(0, 0, 0);
      check("stall_out_pc",    W'(out_pc),    W'(32'h0));
      check("stall_imem_addr", W'(imem_addr), W'(32'h8));

      // Redirect while full and ready: no pop, target appears two cycles later.
      step(1, 1, 32'h100);
      check("redir_flush_valid", W'(out_valid), W'(1'b0));
      step(1, 0, 0);
      check("redir_first_pc", W'(out_pc), W'(32'h100));
      for (int i = 0; i < 4; i++) step(1, 0, 0);

      // Reset mid-stream with entries buffered.
      for (int i = 0; i < 3; i++) step(0, 0, 0);
      reset_pulse();
      for (int i = 0; i < 4; i++) step(1, 0, 0);

      // Misaligned target, end-of-memory crossing, 32-bit wrap.
      step(1, 1, 32'h102);
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      step(1, 1, 32'hFFC);
      for (int i = 0; i < 5; i++) step(1, 0, 0);
      step(1, 1, 32'hFFFF_FFF8);
      for (int i = 0; i < 5; i++) step(1, 0, 0);

      // Randomized traffic.
      for (int i = 0; i < 800; i++) begin
         logic [31:0] tgt;
         bit          rv;
         bit          rdy;
         rdy = ($urandom_range(0, 3) != 0);
         rv  = ($urandom_range(0, 15) == 0);
         case ($urandom_range(0, 3))
            0:       tgt = 32'($urandom_range(0, 1023)) * 32'd4;
            1:       tgt = 32'($urandom_range(0, 4095));
            2:       tgt = 32'hFF0 + 32'($urandom_range(0, 3)) * 32'd4;
            default: tgt = $urandom;
         endcase
         step(rdy, rv, tgt);
      end

      step(0, 0, 0);
      @(negedge clk);
      check("exp_q_drained", W'(exp_q.size()), W'(0));
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
